priority_encoder_seq: RTL and testbench
=======================================

# priority_encoder_seq

Parametrised, handshaked successor to the fixed 8-to-3 and 16-to-4 priority encoders. It captures a WIDTH-bit request vector and emits the index of every set bit, one index per accepted output beat, highest index first. Enable, group-select and empty semantics match the existing encoders: EI gates the block, GS marks valid output, and EO flags an all-zero input. It sits between request collectors (interrupt and pending-flag registers) and downstream servicing logic that handles one request at a time.

## Interface
- WIDTH, 16: request vector width; must be ≥ 2.
- IDX_W, $clog2(WIDTH): index width; derived, not overridden.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- EI  in  1  enable input; when low, no new vector is accepted.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a vector.
- in_vec  in  WIDTH  request vector.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts out_idx.
- out_idx  out  IDX_W  index of the current highest pending bit.
- out_last  out  1  out_idx is the final pending bit of this vector.
- GS  out  1  group select; equals out_valid.
- EO  out  1  one-cycle pulse: accepted vector was all zeros.

## Operation
- State register: IDLE, SCAN. Internal pend[WIDTH-1:0] register.
- IDLE:
  - in_ready = EI.
  - On accept (in_valid & in_ready), if in_vec == 0: stay in IDLE, set EO register to 1 for the next cycle.
  - On accept with in_vec != 0: pend <= in_vec, go to SCAN.
- SCAN:
  - in_ready = 0 and out_valid = 1.
  - out_idx = highest set bit of pend.
  - out_last = pend has exactly one bit set.
- Output beat (out_valid & out_ready): clear the bit at out_idx in pend.
  - If out_last is 1, go to IDLE with pend <= 0.
  - Otherwise stay in SCAN.
- Without an output beat, pend, out_idx and out_last hold stable. The valid/ready hold rule applies: out_valid is never dropped without a beat.
- EI falling during SCAN does not abort the scan. Draining continues; only acceptance of new vectors is blocked.
- in_vec is sampled only on accept. Changes to it during SCAN are ignored.
- EO is registered and is 1 only in the cycle after an all-zero accept. It is 0 otherwise, including when EI is low.

## Timing
- Reset (rst_n low at an edge): state=IDLE, pend=0, EO=0. Resulting outputs: out_valid=0, GS=0, out_last=0, out_idx=0, in_ready=EI.
- Reset has priority over every other event. Reset asserted mid-SCAN discards pending bits with no further beats.
- Latency: vector accepted at edge N gives out_valid=1 in the cycle after edge N.
- Throughput: one index per cycle while out_ready is held high. A vector with k set bits occupies SCAN for exactly k cycles.
- No back-to-back vectors: after the out_last beat at edge M, in_ready rises in the cycle after M. A new vector is accepted no earlier than edge M+1.
- out_idx, out_last and GS are derived combinationally from registered state only. There is no input-to-output combinational path except in_ready ← EI.

## Configuration
- PRIO_LSB_FIRST_EN:
  - Defined: indices are emitted lowest set bit first. out_idx is the lowest set bit of pend.
  - Undefined (default): highest set bit first, matching the legacy encoders.
- out_last, EO and the handshake are identical in both builds.

## Structure
- Package prio_enc_pkg holds:
  - the state enum type (IDLE, SCAN);
  - a function idx_w(width) returning $clog2(width), used to derive IDX_W.
- One sub-module, prio_enc_comb: a parametrised combinational priority encoder over WIDTH bits.
  - Outputs: index, any_set, and one_hot_only (exactly one bit set).
  - Scan direction is selected by the PRIO_LSB_FIRST_EN macro.
  - The top instantiates it once on pend.

## Test plan
- Reset: hold rst_n=0 three cycles with in_valid=1 and in_vec=16'hFFFF, EI=1 → out_valid=0, EO=0, in_ready=1, no accept takes effect.
- Basic drain: in_vec=16'h8421, out_ready=1 → out_idx 15, 10, 5, 0 on four consecutive cycles; out_last=1 only on index 0; in_ready=1 the following cycle.
- Backpressure: in_vec=16'h0006, out_ready=0 for 3 cycles, then 1 → out_idx=2 held stable for 4 cycles, then index 1 with out_last=1.
- Empty and disable:
  - in_vec=0 accepted → EO=1 for exactly one cycle, out_valid stays 0.
  - EI=0 → in_ready=0, no accept, EO=0.
- EI and reset mid-scan:
  - Accept 16'hC000, drop EI → both indices 15 and 14 are still emitted.
  - Repeat and assert rst_n=0 after the first beat → out_valid=0 the next cycle, index 14 never emitted.
- PRIO_LSB_FIRST_EN build, WIDTH=8, in_vec=8'b1001_0010 → out_idx 1, 4, 7 with out_last on 7.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
package prio_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder over WIDTH bits.
// Scan direction: highest set bit wins by default; PRIO_LSB_FIRST_EN makes the lowest set bit win.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             any_set,
  output logic             one_hot_only
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    index = '0;
`ifdef PRIO_LSB_FIRST_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
`else
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) index = IDX_W'(i);
    end
`endif
    any_set      = |vec;
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    one_hot_only = any_set && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/priority_encoder_seq.sv
// Handshaked sequential priority encoder: captures a request vector and emits one index per beat.
// Optional build macro PRIO_LSB_FIRST_EN reverses the emission order (lowest index first).
module priority_encoder_seq
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EI,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             GS,
  output logic             EO
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               eo_q, eo_d;

  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               enc_one;

  prio_enc_comb #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec          (pend_q),
    .index        (enc_idx),
    .any_set      (enc_any),
    .one_hot_only (enc_one)
  );

  // NOTE: pend_q is a plain register, not a memory, so it is reset to make stale bits impossible after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      eo_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q <= state_d;
      pend_q  <= pend_d;
      eo_q    <= eo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    eo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in_vec == '0) begin
            eo_d = 1'b1;
          end else begin
            pend_d  = in_vec;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            pend_d  = '0;
            state_d = IDLE;
          end else begin
            pend_d[enc_idx] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only, apart from in_ready following EI.
  always_comb begin
    out_valid = (state_q == SCAN) && enc_any;
    in_ready  = (state_q == IDLE) && EI;
    out_idx   = enc_idx;
    out_last  = out_valid && enc_one;
    GS        = out_valid;
    EO        = eo_q;
  end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed self-checking bench for priority_encoder_seq (default build WIDTH=16, PRIO_LSB_FIRST_EN build WIDTH=8).
module tb_priority_encoder_seq;

`ifdef PRIO_LSB_FIRST_EN
  localparam int W = 8;
`else
  localparam int W = 16;
`endif
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          EI;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          GS;
  logic          EO;

  int passed = 0;
  int total  = 0;

  priority_encoder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EI        (EI),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .GS        (GS),
    .EO        (EO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for one edge and check it was acceptable.
  task automatic send(input logic [W-1:0] vec);
    in_valid = 1'b1;
    in_vec   = vec;
    total++;
    if (in_ready !== 1'b1) $display("FAIL send_in_ready: got %b want 1", in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    EI        = 1'b1;
    in_valid  = 1'b1;
    in_vec    = '1;
    out_ready = 1'b1;
    repeat (3) step();
    total++;
    if ({out_valid, GS, EO, out_last, in_ready} !== 5'b00001)
      $display("FAIL reset_flags: got v=%b gs=%b eo=%b last=%b rdy=%b want 0 0 0 0 1",
               out_valid, GS, EO, out_last, in_ready);
    else passed++;
    total++;
    if (out_idx !== '0) $display("FAIL reset_idx: got %0d want 0", out_idx);
    else passed++;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || EO !== 1'b0)
      $display("FAIL reset_no_accept: got v=%b eo=%b want 0 0", out_valid, EO);
    else passed++;
  endtask

`ifdef PRIO_LSB_FIRST_EN
  task automatic test_lsb_first();
    int exp_idx [3] = '{1, 4, 7};
    out_ready = 1'b1;
    send(8'b1001_0010);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== IW'(exp_idx[i]) || out_last !== (i == 2))
        $display("FAIL lsb_beat%0d: got v=%b idx=%0d last=%b want 1 %0d %b",
                 i, out_valid, out_idx, out_last, exp_idx[i], (i == 2));
      else passed++;
      step();
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL lsb_done: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    else passed++;
  endtask
`else
  task automatic test_basic_drain();
    int exp_idx [4] = '{15, 10, 5, 0};
    out_ready = 1'b1;
    send(16'h8421);
    in_vec = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || GS !== 1'b1 || out_idx !== IW'(exp_idx[i]) || out_last !== (i == 3))
        $display("FAIL drain_beat%0d: got v=%b gs=%b idx=%0d last=%b want 1 1 %0d %b",
                 i, out_valid, GS, out_idx, out_last, exp_idx[i], (i == 3));
      else passed++;
      total++;
      if (in_ready !== 1'b0) $display("FAIL drain_busy%0d: in_ready got %b want 0", i, in_ready);
      else passed++;
      step();
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0)
      $display("FAIL drain_done: got v=%b rdy=%b last=%b want 0 1 0", out_valid, in_ready, out_last);
    else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(16'h0006);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b1 || out_idx !== IW'(2) || out_last !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b idx=%0d last=%b want 1 2 0", i, out_valid, out_idx, out_last);
      else passed++;
      step();
    end
    total++;
    if (out_valid !== 1'b1 || out_idx !== IW'(1) || out_last !== 1'b1)
      $display("FAIL bp_last: got v=%b idx=%0d last=%b want 1 1 1", out_valid, out_idx, out_last);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL bp_done: out_valid got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_empty_and_disable();
    send('0);
    total++;
    if (EO !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL empty_eo: got eo=%b v=%b want 1 0", EO, out_valid);
    else passed++;
    step();
    total++;
    if (EO !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL empty_eo_pulse: got eo=%b v=%b want 0 0", EO, out_valid);
    else passed++;
    EI       = 1'b0;
    in_valid = 1'b1;
    in_vec   = '0;
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL disable_ready: got %b want 0", in_ready);
    else passed++;
    step();
    total++;
    if (EO !== 1'b0) $display("FAIL disable_eo: got %b want 0", EO);
    else passed++;
    in_vec = 16'h00FF;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL disable_no_accept: out_valid got %b want 0", out_valid);
    else passed++;
    in_valid = 1'b0;
    EI       = 1'b1;
    #1;
  endtask

  task automatic test_ei_mid_scan();
    out_ready = 1'b1;
    send(16'hC000);
    EI = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_idx !== IW'(15) || in_ready !== 1'b0)
      $display("FAIL ei_beat0: got v=%b idx=%0d rdy=%b want 1 15 0", out_valid, out_idx, in_ready);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b1 || out_idx !== IW'(14) || out_last !== 1'b1)
      $display("FAIL ei_beat1: got v=%b idx=%0d last=%b want 1 14 1", out_valid, out_idx, out_last);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL ei_done: got v=%b rdy=%b want 0 0", out_valid, in_ready);
    else passed++;
    EI = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid_scan();
    out_ready = 1'b1;
    send(16'hC000);
    step();
    total++;
    if (out_valid !== 1'b1 || out_idx !== IW'(14))
      $display("FAIL rst_scan_pre: got v=%b idx=%0d want 1 14", out_valid, out_idx);
    else passed++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (out_valid !== 1'b0 || GS !== 1'b0) $display("FAIL rst_scan_drop: got v=%b gs=%b want 0 0", out_valid, GS);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL rst_scan_quiet%0d: out_valid got %b want 0", i, out_valid);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(16'h0001);
    in_valid = 1'b1;
    in_vec   = 16'h0003;
    total++;
    if (out_last !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL b2b_last: got last=%b rdy=%b want 1 0", out_last, in_ready);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_gap: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_idx !== IW'(1) || out_last !== 1'b0)
      $display("FAIL b2b_next: got v=%b idx=%0d last=%b want 1 1 0", out_valid, out_idx, out_last);
    else passed++;
    repeat (2) step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_done: out_valid got %b want 0", out_valid);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef PRIO_LSB_FIRST_EN
    test_lsb_first();
`else
    test_basic_drain();
    test_backpressure();
    test_empty_and_disable();
    test_ei_mid_scan();
    test_reset_mid_scan();
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
